// File: rtl/mem_if_pkg.sv
// ----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the DDR memory-port handshake: address/data widths,
// the arbiter state encoding and the read/write direction encoding.
// ----------------------------------------------------------------------------
package mem_if_pkg;

   localparam int unsigned MEM_ADDR_W = 28;
   localparam int unsigned MEM_DATA_W = 256;

   // Direction encoding carried on *_rw.
   localparam logic MEM_WRITE = 1'b1;
   localparam logic MEM_READ  = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

endpackage : mem_if_pkg

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way arbiter pick.
//   valid_i      : request valids, bit 0 = port 0, bit 1 = port 1
//   last_grant_i : port served most recently
//   any_o        : at least one request present
//   winner_o     : port to grant (meaningful only when any_o = 1)
// FAIR = 1 alternates on contention; FAIR = 0 gives port 0 fixed priority.
// ----------------------------------------------------------------------------
module rr_arb2 #(
   parameter bit FAIR = 1'b1
) (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       any_o,
   output logic       winner_o
);

   always_comb begin
      any_o    = |valid_i;
      winner_o = 1'b0;
      unique case (valid_i)
         2'b01:   winner_o = 1'b0;
         2'b10:   winner_o = 1'b1;
         2'b11:   winner_o = FAIR ? ~last_grant_i : 1'b0;
         default: winner_o = 1'b0;
      endcase
   end

endmodule : rr_arb2

// File: rtl/ddr_port_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_port_arbiter
// Shares the single DDR2 controller command port between two requesters
// (port 0: display scan-out reads, port 1: cache / framebuffer traffic).
// One request is granted at a time and registered onto the mem_* port; the
// read data and a one-cycle ready pulse go back to the granted requester.
// A stalled DDR response raises the sticky timeout_err flag.
//
// Ports
//   clk, rst                 : clock, asynchronous active-low reset
//   pN_valid/rw/addr/data_wr : requester N command (rw: 1 = write, 0 = read)
//   pN_data_rd, pN_ready     : requester N read data and completion pulse
//   mem_valid/rw/addr/data_wr: registered DDR command
//   mem_data_rd, mem_ready   : DDR read data and completion pulse
//   grant                    : port currently or last served
//   timeout_err              : sticky, set after TIMEOUT_CYCLES in ISSUE
// ----------------------------------------------------------------------------
module ddr_port_arbiter
   import mem_if_pkg::*;
#(
   parameter int unsigned FAIR           = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  p0_valid,
   input  logic                  p0_rw,
   input  logic [MEM_ADDR_W-1:0] p0_addr,
   input  logic [MEM_DATA_W-1:0] p0_data_wr,
   output logic [MEM_DATA_W-1:0] p0_data_rd,
   output logic                  p0_ready,

   input  logic                  p1_valid,
   input  logic                  p1_rw,
   input  logic [MEM_ADDR_W-1:0] p1_addr,
   input  logic [MEM_DATA_W-1:0] p1_data_wr,
   output logic [MEM_DATA_W-1:0] p1_data_rd,
   output logic                  p1_ready,

   output logic                  mem_valid,
   output logic                  mem_rw,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [MEM_DATA_W-1:0] mem_data_wr,
   input  logic [MEM_DATA_W-1:0] mem_data_rd,
   input  logic                  mem_ready,

   output logic                  grant,
   output logic                  timeout_err
);

   // Counter value at which the stall flag is raised.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e                  state_q;
   logic                    mem_valid_q;
   logic                    mem_rw_q;
   logic [MEM_ADDR_W-1:0]   mem_addr_q;
   logic [MEM_DATA_W-1:0]   mem_data_wr_q;
   logic [MEM_DATA_W-1:0]   p0_data_rd_q;
   logic [MEM_DATA_W-1:0]   p1_data_rd_q;
   logic                    p0_ready_q;
   logic                    p1_ready_q;
   logic                    grant_q;
   logic                    last_grant_q;
   logic                    timeout_err_q;
   logic [15:0]             to_cnt_q;

   logic                    arb_any_d;
   logic                    arb_win_d;

   rr_arb2 #(
      .FAIR (FAIR != 0)
   ) u_rr_arb2 (
      .valid_i      ({p1_valid, p0_valid}),
      .last_grant_i (last_grant_q),
      .any_o        (arb_any_d),
      .winner_o     (arb_win_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         mem_valid_q   <= 1'b0;
         mem_rw_q      <= MEM_READ;
         mem_addr_q    <= '0;
         mem_data_wr_q <= '0;
         p0_data_rd_q  <= '0;
         p1_data_rd_q  <= '0;
         p0_ready_q    <= 1'b0;
         p1_ready_q    <= 1'b0;
         grant_q       <= 1'b0;
         // Port 0 must win the first contention after reset.
         last_grant_q  <= 1'b1;
         timeout_err_q <= 1'b0;
         to_cnt_q      <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (arb_any_d) begin
                  grant_q      <= arb_win_d;
                  last_grant_q <= arb_win_d;
                  if (arb_win_d) begin
                     mem_rw_q      <= p1_rw;
                     mem_addr_q    <= p1_addr;
                     mem_data_wr_q <= p1_data_wr;
                  end else begin
                     mem_rw_q      <= p0_rw;
                     mem_addr_q    <= p0_addr;
                     mem_data_wr_q <= p0_data_wr;
                  end
                  mem_valid_q <= 1'b1;
                  to_cnt_q    <= '0;
                  state_q     <= ISSUE;
               end
            end

            ISSUE: begin
               if (mem_ready) begin
                  // Writes also capture mem_data_rd; the content is don't-care.
                  if (grant_q) begin
                     p1_data_rd_q <= mem_data_rd;
                     p1_ready_q   <= 1'b1;
                  end else begin
                     p0_data_rd_q <= mem_data_rd;
                     p0_ready_q   <= 1'b1;
                  end
                  mem_valid_q <= 1'b0;
                  state_q     <= RESP;
               end else begin
                  if (to_cnt_q != '1) begin
                     to_cnt_q <= to_cnt_q + 16'd1;
                  end
                  // Flag only; the transaction keeps waiting for mem_ready.
                  if (to_cnt_q >= TO_LAST) begin
                     timeout_err_q <= 1'b1;
                  end
               end
            end

            RESP: begin
               p0_ready_q <= 1'b0;
               p1_ready_q <= 1'b0;
               state_q    <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_valid   = mem_valid_q;
   assign mem_rw      = mem_rw_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data_wr = mem_data_wr_q;
   assign p0_data_rd  = p0_data_rd_q;
   assign p1_data_rd  = p1_data_rd_q;
   assign p0_ready    = p0_ready_q;
   assign p1_ready    = p1_ready_q;
   assign grant       = grant_q;
   assign timeout_err = timeout_err_q;

endmodule : ddr_port_arbiter

// File: tb/tb_ddr_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr_port_arbiter
// Two arbiters share the same requester and DDR-side stimulus:
//   dut_a : FAIR = 1, TIMEOUT_CYCLES = 8
//   dut_b : FAIR = 0, TIMEOUT_CYCLES = 1024 (default)
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ddr_port_arbiter;
   import mem_if_pkg::*;

   logic                  clk;
   logic                  rst;
   logic                  p0_valid, p0_rw, p1_valid, p1_rw;
   logic [MEM_ADDR_W-1:0] p0_addr, p1_addr;
   logic [MEM_DATA_W-1:0] p0_data_wr, p1_data_wr;
   logic [MEM_DATA_W-1:0] mem_data_rd;
   logic                  mem_ready;

   logic [MEM_DATA_W-1:0] a_p0_data_rd, a_p1_data_rd, b_p0_data_rd, b_p1_data_rd;
   logic                  a_p0_ready, a_p1_ready, b_p0_ready, b_p1_ready;
   logic                  a_mem_valid, a_mem_rw, b_mem_valid, b_mem_rw;
   logic [MEM_ADDR_W-1:0] a_mem_addr, b_mem_addr;
   logic [MEM_DATA_W-1:0] a_mem_data_wr, b_mem_data_wr;
   logic                  a_grant, b_grant, a_timeout_err, b_timeout_err;

   int n_asrt = 0;
   int n_fail = 0;

   ddr_port_arbiter #(
      .FAIR           (1),
      .TIMEOUT_CYCLES (8)
   ) dut_a (
      .clk         (clk),
      .rst         (rst),
      .p0_valid    (p0_valid),
      .p0_rw       (p0_rw),
      .p0_addr     (p0_addr),
      .p0_data_wr  (p0_data_wr),
      .p0_data_rd  (a_p0_data_rd),
      .p0_ready    (a_p0_ready),
      .p1_valid    (p1_valid),
      .p1_rw       (p1_rw),
      .p1_addr     (p1_addr),
      .p1_data_wr  (p1_data_wr),
      .p1_data_rd  (a_p1_data_rd),
      .p1_ready    (a_p1_ready),
      .mem_valid   (a_mem_valid),
      .mem_rw      (a_mem_rw),
      .mem_addr    (a_mem_addr),
      .mem_data_wr (a_mem_data_wr),
      .mem_data_rd (mem_data_rd),
      .mem_ready   (mem_ready),
      .grant       (a_grant),
      .timeout_err (a_timeout_err)
   );

   ddr_port_arbiter #(
      .FAIR (0)
   ) dut_b (
      .clk         (clk),
      .rst         (rst),
      .p0_valid    (p0_valid),
      .p0_rw       (p0_rw),
      .p0_addr     (p0_addr),
      .p0_data_wr  (p0_data_wr),
      .p0_data_rd  (b_p0_data_rd),
      .p0_ready    (b_p0_ready),
      .p1_valid    (p1_valid),
      .p1_rw       (p1_rw),
      .p1_addr     (p1_addr),
      .p1_data_wr  (p1_data_wr),
      .p1_data_rd  (b_p1_data_rd),
      .p1_ready    (b_p1_ready),
      .mem_valid   (b_mem_valid),
      .mem_rw      (b_mem_rw),
      .mem_addr    (b_mem_addr),
      .mem_data_wr (b_mem_data_wr),
      .mem_data_rd (mem_data_rd),
      .mem_ready   (mem_ready),
      .grant       (b_grant),
      .timeout_err (b_timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_asrt++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // One uncontended transaction; mem_ready is returned in ISSUE cycle 'lat'.
   task automatic run_xact(input string tag, input bit port, input bit rw,
                           input logic [27:0] addr, input logic [255:0] wd,
                           input logic [255:0] rd, input int lat);
      if (port) begin
         p1_valid = 1'b1; p1_rw = rw; p1_addr = addr; p1_data_wr = wd;
      end else begin
         p0_valid = 1'b1; p0_rw = rw; p0_addr = addr; p0_data_wr = wd;
      end
      tick();
      chk({tag, "_a_valid"}, 256'(a_mem_valid), 256'(1));
      chk({tag, "_a_rw"},    256'(a_mem_rw),    256'(rw));
      chk({tag, "_a_addr"},  256'(a_mem_addr),  256'(addr));
      chk({tag, "_a_wdata"}, a_mem_data_wr,     wd);
      chk({tag, "_a_grant"}, 256'(a_grant),     256'(port));
      chk({tag, "_b_addr"},  256'(b_mem_addr),  256'(addr));
      chk({tag, "_b_grant"}, 256'(b_grant),     256'(port));
      for (int j = 1; j < lat; j++) begin
         tick();
         chk({tag, "_a_hold"},   256'(a_mem_valid), 256'(1));
         chk({tag, "_a_noaddr"}, 256'(a_mem_addr),  256'(addr));
         chk({tag, "_a_nordy"},  256'({a_p1_ready, a_p0_ready}), 256'(0));
      end
      mem_ready = 1'b1; mem_data_rd = rd;
      tick();
      mem_ready = 1'b0; mem_data_rd = '1;
      chk({tag, "_a_rdy"},   256'({a_p1_ready, a_p0_ready}), port ? 256'(2) : 256'(1));
      chk({tag, "_b_rdy"},   256'({b_p1_ready, b_p0_ready}), port ? 256'(2) : 256'(1));
      chk({tag, "_a_rdata"}, port ? a_p1_data_rd : a_p0_data_rd, rd);
      chk({tag, "_b_rdata"}, port ? b_p1_data_rd : b_p0_data_rd, rd);
      chk({tag, "_a_mvclr"}, 256'(a_mem_valid), 256'(0));
      tick();
      chk({tag, "_a_rdy_end"}, 256'({a_p1_ready, a_p0_ready}), 256'(0));
      chk({tag, "_a_rd_hold"}, port ? a_p1_data_rd : a_p0_data_rd, rd);
      if (port) p1_valid = 1'b0; else p0_valid = 1'b0;
      tick();
      chk({tag, "_a_no_reissue"}, 256'(a_mem_valid), 256'(0));
      chk({tag, "_b_no_reissue"}, 256'(b_mem_valid), 256'(0));
   endtask

   int exp_a[5] = '{0, 1, 0, 1, 1};
   int exp_b[5] = '{0, 0, 0, 0, 1};

   initial begin
      rst = 1'b0;
      p0_valid = 1'b0; p0_rw = MEM_READ; p0_addr = '0; p0_data_wr = '0;
      p1_valid = 1'b0; p1_rw = MEM_READ; p1_addr = '0; p1_data_wr = '0;
      mem_data_rd = '0; mem_ready = 1'b0;

      // Reset values
      tick(); tick();
      chk("rst_a_mem_valid", 256'(a_mem_valid), 256'(0));
      chk("rst_a_mem_rw",    256'(a_mem_rw),    256'(0));
      chk("rst_a_mem_addr",  256'(a_mem_addr),  256'(0));
      chk("rst_a_mem_wdata", a_mem_data_wr,     256'(0));
      chk("rst_a_ready",     256'({a_p1_ready, a_p0_ready}), 256'(0));
      chk("rst_a_p0_rd",     a_p0_data_rd,      256'(0));
      chk("rst_a_p1_rd",     a_p1_data_rd,      256'(0));
      chk("rst_a_grant",     256'(a_grant),     256'(0));
      chk("rst_a_timeout",   256'(a_timeout_err), 256'(0));
      chk("rst_a_state",     256'(dut_a.state_q), 256'(IDLE));
      chk("rst_b_mem_valid", 256'(b_mem_valid), 256'(0));
      rst = 1'b1;
      tick();
      chk("idle_a_mem_valid", 256'(a_mem_valid), 256'(0));

      // Contention: A alternates starting at port 0, B keeps picking port 0
      // until p0_valid drops.
      p0_valid = 1'b1; p0_rw = MEM_READ;  p0_addr = 28'h100; p0_data_wr = 256'h11;
      p1_valid = 1'b1; p1_rw = MEM_WRITE; p1_addr = 28'h104; p1_data_wr = 256'h22;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("cont_a_valid", 256'(a_mem_valid), 256'(1));
         chk("cont_a_grant", 256'(a_grant), 256'(exp_a[i]));
         chk("cont_a_addr",  256'(a_mem_addr), exp_a[i] == 1 ? 256'h104 : 256'h100);
         chk("cont_a_wdata", a_mem_data_wr,    exp_a[i] == 1 ? 256'h22 : 256'h11);
         chk("cont_b_grant", 256'(b_grant), 256'(exp_b[i]));
         chk("cont_b_addr",  256'(b_mem_addr), exp_b[i] == 1 ? 256'h104 : 256'h100);
         mem_ready = 1'b1; mem_data_rd = 256'(32'hC0 + i);
         tick();
         mem_ready = 1'b0;
         chk("cont_a_rdy", 256'({a_p1_ready, a_p0_ready}), exp_a[i] == 1 ? 256'(2) : 256'(1));
         chk("cont_b_rdy", 256'({b_p1_ready, b_p0_ready}), exp_b[i] == 1 ? 256'(2) : 256'(1));
         chk("cont_a_rdata", exp_a[i] == 1 ? a_p1_data_rd : a_p0_data_rd, 256'(32'hC0 + i));
         tick();
         chk("cont_a_idle_gap", 256'(a_mem_valid), 256'(0));
         chk("cont_b_idle_gap", 256'(b_mem_valid), 256'(0));
         chk("cont_a_rdy_end", 256'({a_p1_ready, a_p0_ready}), 256'(0));
         if (i == 3) p0_valid = 1'b0;
         if (i == 4) p1_valid = 1'b0;
         tick();
      end
      chk("cont_a_drained", 256'(a_mem_valid), 256'(0));
      chk("cont_b_drained", 256'(b_mem_valid), 256'(0));

      // Single write on port 1, mem_ready in the 4th ISSUE cycle
      run_xact("wr1", 1'b1, MEM_WRITE, 28'h0000010, 256'hAB, 256'h5555, 4);
      chk("wr1_a_p0_rdy", 256'(a_p0_ready), 256'(0));

      // Read on port 0
      run_xact("rd0", 1'b0, MEM_READ, 28'h0000200, 256'h0, 256'hDEADBEEF, 1);
      chk("rd0_p1_untouched", a_p1_data_rd, 256'h5555);

      // mem_ready in IDLE is ignored
      mem_ready = 1'b1; mem_data_rd = 256'hBAD;
      tick();
      mem_ready = 1'b0;
      chk("idle_rdy_a_ready", 256'({a_p1_ready, a_p0_ready}), 256'(0));
      chk("idle_rdy_a_p0_rd", a_p0_data_rd, 256'hDEADBEEF);
      chk("idle_rdy_a_valid", 256'(a_mem_valid), 256'(0));
      tick();
      chk("idle_rdy_a_p0_rd2", a_p0_data_rd, 256'hDEADBEEF);
      chk("idle_rdy_a_state", 256'(dut_a.state_q), 256'(IDLE));

      // Timeout: mem_ready withheld for 20 ISSUE cycles
      p0_valid = 1'b1; p0_rw = MEM_READ; p0_addr = 28'h300; p0_data_wr = '0;
      tick();
      for (int j = 1; j <= 20; j++) begin
         chk("to_a_valid", 256'(a_mem_valid), 256'(1));
         chk("to_a_err",   256'(a_timeout_err), 256'(j >= 9));
         chk("to_b_err",   256'(b_timeout_err), 256'(0));
         if (j < 20) tick();
      end
      mem_ready = 1'b1; mem_data_rd = 256'h77;
      tick();
      mem_ready = 1'b0;
      chk("to_late_a_rdy",   256'(a_p0_ready), 256'(1));
      chk("to_late_a_rdata", a_p0_data_rd, 256'h77);
      chk("to_late_a_err",   256'(a_timeout_err), 256'(1));
      tick();
      p0_valid = 1'b0;
      chk("to_late_a_rdy_end", 256'(a_p0_ready), 256'(0));
      tick();
      chk("to_a_idle", 256'(a_mem_valid), 256'(0));
      run_xact("after_to", 1'b1, MEM_READ, 28'h0000044, 256'h0, 256'h1234, 2);
      chk("to_a_err_sticky", 256'(a_timeout_err), 256'(1));

      // Asynchronous reset mid-ISSUE
      p1_valid = 1'b1; p1_rw = MEM_WRITE; p1_addr = 28'h40; p1_data_wr = 256'h99;
      tick();
      chk("ar_pre_a_valid", 256'(a_mem_valid), 256'(1));
      chk("ar_pre_a_err",   256'(a_timeout_err), 256'(1));
      #2 rst = 1'b0;
      #1;
      chk("ar_a_valid", 256'(a_mem_valid), 256'(0));
      chk("ar_b_valid", 256'(b_mem_valid), 256'(0));
      chk("ar_a_state", 256'(dut_a.state_q), 256'(IDLE));
      chk("ar_b_state", 256'(dut_b.state_q), 256'(IDLE));
      chk("ar_a_err",   256'(a_timeout_err), 256'(0));
      chk("ar_a_grant", 256'(a_grant), 256'(0));
      chk("ar_a_addr",  256'(a_mem_addr), 256'(0));
      chk("ar_a_p0_rd", a_p0_data_rd, 256'(0));
      tick();
      rst = 1'b1;
      tick();
      chk("ar_post_a_valid", 256'(a_mem_valid), 256'(1));
      chk("ar_post_a_grant", 256'(a_grant), 256'(1));
      chk("ar_post_a_addr",  256'(a_mem_addr), 256'h40);
      chk("ar_post_a_rw",    256'(a_mem_rw), 256'(1));
      chk("ar_post_a_wdata", a_mem_data_wr, 256'h99);
      mem_ready = 1'b1; mem_data_rd = 256'h3;
      tick();
      mem_ready = 1'b0;
      chk("ar_post_a_rdy", 256'({a_p1_ready, a_p0_ready}), 256'(2));
      tick();
      p1_valid = 1'b0;
      tick();
      chk("ar_post_a_idle", 256'(a_mem_valid), 256'(0));
      chk("ar_post_a_err",  256'(a_timeout_err), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule : tb_ddr_port_arbiter
